// File: rtl/vector_pkg.sv
// Shared definitions for the vector sequencer: op-codes, coordinate width,
// the packed FIFO command word and the sequencer state encoding.
package vector_pkg;

  localparam int COORD_W = 12;

  localparam logic [1:0] OP_JUMP      = 2'd0;
  localparam logic [1:0] OP_DRAW      = 2'd1;
  localparam logic [1:0] OP_TRAVEL    = 2'd2;
  localparam logic [1:0] OP_END_FRAME = 2'd3;

  typedef struct packed {
    logic [1:0]         op;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vec_cmd_t;

  localparam int CMD_W = 2 + 2 * COORD_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_t;

  // True for commands that move the beam (everything except END_FRAME).
  function automatic logic is_beam_op(input logic [1:0] op);
    return (op != OP_END_FRAME);
  endfunction

endpackage

// File: rtl/vector_cmd_fifo.sv
// Synchronous circular command FIFO with count-based full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module vector_cmd_fifo
  import vector_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [CMD_W-1:0]       push_data,
  input  logic                   pop,
  output logic [CMD_W-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign level     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
    end else if (do_pop && !do_push) begin
      count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vector_sequencer.sv
// Buffers vector commands and issues them to beam control one per HOLD cycle,
// parking the beam when starved. Optional counters: VECTOR_SEQ_STATS_EN.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PARK_TIMEOUT = 4096,
  parameter int PARK_X       = 2048,
  parameter int PARK_Y       = 2048
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [11:0]            cmd_x,
  input  logic [11:0]            cmd_y,
  input  logic                   ctl_ready,
  output logic [11:0]            ctl_x,
  output logic [11:0]            ctl_y,
  output logic                   ctl_jump,
  output logic                   ctl_draw,
  output logic                   ctl_travel,
  output logic                   frame_done,
  output logic                   parked,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef VECTOR_SEQ_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [15:0]            vector_count,
  output logic [15:0]            vector_count_last
`endif
);

  localparam int                 STARVE_W   = 13;
  localparam logic [STARVE_W-1:0] STARVE_MAX = {STARVE_W{1'b1}};
  localparam logic [STARVE_W-1:0] PARK_LIMIT = STARVE_W'(PARK_TIMEOUT);
  localparam logic               PARK_EN    = (PARK_TIMEOUT != 0);
  localparam logic [COORD_W-1:0] PARK_X_C   = COORD_W'(PARK_X);
  localparam logic [COORD_W-1:0] PARK_Y_C   = COORD_W'(PARK_Y);

  seq_state_t          state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic                jump_q, jump_d;
  logic                draw_q, draw_d;
  logic                travel_q, travel_d;
  logic                frame_done_q, frame_done_d;
  logic                parked_q, parked_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [CMD_W-1:0]    head_data;
  vec_cmd_t            head;
  vec_cmd_t            in_cmd;
  logic                starving;
  logic                park_due;
  logic                issue_vec;
  logic                issue_end;

  assign in_cmd    = '{op: cmd_op, x: cmd_x, y: cmd_y};
  assign head      = head_data;
  assign cmd_ready = !fifo_full;

  vector_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (in_cmd),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign starving = fifo_empty && ctl_ready && !parked_q;
  assign park_due = PARK_EN && starving && (starve_q >= PARK_LIMIT);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    jump_d       = 1'b0;
    draw_d       = 1'b0;
    travel_d     = travel_q;
    frame_done_d = 1'b0;
    parked_d     = parked_q;
    starve_d     = starve_q;
    fifo_pop     = 1'b0;
    issue_vec    = 1'b0;
    issue_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A queued command always beats a pending park.
        if (!fifo_empty && ctl_ready) begin
          fifo_pop = 1'b1;
          starve_d = '0;
          state_d  = ST_HOLD;
          if (is_beam_op(head.op)) begin
            issue_vec = 1'b1;
            x_d       = head.x;
            y_d       = head.y;
            parked_d  = 1'b0;
            jump_d    = (head.op == OP_JUMP);
            draw_d    = (head.op != OP_JUMP);
            if (head.op != OP_JUMP) begin
              travel_d = (head.op == OP_TRAVEL);
            end else begin
              travel_d = travel_q;
            end
          end else begin
            issue_end    = 1'b1;
            frame_done_d = 1'b1;
          end
        end else if (park_due) begin
          jump_d   = 1'b1;
          x_d      = PARK_X_C;
          y_d      = PARK_Y_C;
          parked_d = 1'b1;
          starve_d = '0;
          state_d  = ST_HOLD;
        end else if (starving && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
          starve_d = starve_q;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= PARK_X_C;
      y_q          <= PARK_Y_C;
      jump_q       <= 1'b0;
      draw_q       <= 1'b0;
      travel_q     <= 1'b0;
      frame_done_q <= 1'b0;
      parked_q     <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      jump_q       <= jump_d;
      draw_q       <= draw_d;
      travel_q     <= travel_d;
      frame_done_q <= frame_done_d;
      parked_q     <= parked_d;
      starve_q     <= starve_d;
    end
  end

  assign ctl_x      = x_q;
  assign ctl_y      = y_q;
  assign ctl_jump   = jump_q;
  assign ctl_draw   = draw_q;
  assign ctl_travel = travel_q;
  assign frame_done = frame_done_q;
  assign parked     = parked_q;

`ifdef VECTOR_SEQ_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] vector_count_q, vector_count_d;
  logic [15:0] vector_last_q, vector_last_d;

  // Park jumps are not host vectors, so only issue_vec advances the count.
  always_comb begin
    frame_count_d  = frame_count_q;
    vector_count_d = vector_count_q;
    vector_last_d  = vector_last_q;
    if (issue_end) begin
      frame_count_d  = frame_count_q + 16'd1;
      vector_last_d  = vector_count_q;
      vector_count_d = 16'd0;
    end else if (issue_vec) begin
      vector_count_d = vector_count_q + 16'd1;
    end else begin
      vector_count_d = vector_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q  <= 16'd0;
      vector_count_q <= 16'd0;
      vector_last_q  <= 16'd0;
    end else begin
      frame_count_q  <= frame_count_d;
      vector_count_q <= vector_count_d;
      vector_last_q  <= vector_last_d;
    end
  end

  assign frame_count       = frame_count_q;
  assign vector_count      = vector_count_q;
  assign vector_count_last = vector_last_q;
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: stimulus queues expected issue events,
// a negedge monitor pops and compares them. Optional checks: VECTOR_SEQ_STATS_EN.
module tb_vector_sequencer;

  localparam logic [11:0] PARK = 12'd2048;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_x;
  logic [11:0] cmd_y;
  logic        ctl_ready;
  logic [11:0] ctl_x;
  logic [11:0] ctl_y;
  logic        ctl_jump;
  logic        ctl_draw;
  logic        ctl_travel;
  logic        frame_done;
  logic        parked;
  logic [4:0]  fifo_level;
`ifdef VECTOR_SEQ_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] vector_count;
  logic [15:0] vector_count_last;
`endif

  vector_sequencer #(
    .DEPTH        (16),
    .PARK_TIMEOUT (8),
    .PARK_X       (2048),
    .PARK_Y       (2048)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .ctl_ready  (ctl_ready),
    .ctl_x      (ctl_x),
    .ctl_y      (ctl_y),
    .ctl_jump   (ctl_jump),
    .ctl_draw   (ctl_draw),
    .ctl_travel (ctl_travel),
    .frame_done (frame_done),
    .parked     (parked),
    .fifo_level (fifo_level)
`ifdef VECTOR_SEQ_STATS_EN
    ,
    .frame_count       (frame_count),
    .vector_count      (vector_count),
    .vector_count_last (vector_count_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected issue event: kind 0=jump 1=draw 2=travel 3=end-of-frame.
  typedef struct {
    logic [1:0]  kind;
    logic [11:0] x;
    logic [11:0] y;
    logic        travel;
    logic        parked;
    bit          is_park;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_pushed = 0;
  int          n_popped = 0;
  logic [11:0] m_x = PARK;
  logic [11:0] m_y = PARK;
  logic        m_travel = 1'b0;
  logic        m_parked = 1'b0;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: what the beam should see when this command retires.
  task automatic expect_cmd(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y);
    ev_t e;
    if (op == 2'd3) begin
      e = '{kind: op, x: m_x, y: m_y, travel: m_travel, parked: m_parked, is_park: 1'b0};
    end else begin
      m_x = x;
      m_y = y;
      m_parked = 1'b0;
      if (op != 2'd0) m_travel = (op == 2'd2);
      e = '{kind: op, x: x, y: y, travel: m_travel, parked: 1'b0, is_park: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  task automatic expect_park();
    m_x = PARK;
    m_y = PARK;
    m_parked = 1'b1;
    exp_q.push_back('{kind: 2'd0, x: PARK, y: PARK, travel: m_travel, parked: 1'b1, is_park: 1'b1});
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [11:0] x,
                      input logic [11:0] y, input logic rdy);
    cmd_valid = v;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    ctl_ready = rdy;
    if (v && cmd_ready) begin
      expect_cmd(op, x, y);
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_begin();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    ctl_ready = 1'b0;
    exp_q.delete();
    m_x = PARK;
    m_y = PARK;
    m_travel = 1'b0;
    m_parked = 1'b0;
    n_pushed = 0;
    n_popped = 0;
  endtask

  task automatic do_reset();
    reset_begin();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (n_popped == n_pushed) return;
      step(1'b0, 2'd0, 12'd0, 12'd0, n_pushed != n_popped);
    end
    chk({name, "_drain_timeout"}, n_pushed - n_popped, 0);
  endtask

  // Monitor: compares every issue pulse against the scoreboard head.
  logic        rst_at_edge;
  logic        prev_pulse;
  logic [11:0] cur_x;
  logic [11:0] cur_y;
  ev_t         got_e;
  logic [2:0]  exp_p;

  always @(posedge clk) rst_at_edge <= reset;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      prev_pulse = 1'b0;
      cur_x = PARK;
      cur_y = PARK;
    end else if (rst_at_edge === 1'b1) begin
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_flags", int'({ctl_jump, ctl_draw, frame_done, ctl_travel, parked}), 0);
      chk("rst_ctl_x", int'(ctl_x), int'(PARK));
      chk("rst_ctl_y", int'(ctl_y), int'(PARK));
`ifdef VECTOR_SEQ_STATS_EN
      chk("rst_stats", int'({frame_count, vector_count_last}) + int'(vector_count), 0);
`endif
      prev_pulse = 1'b0;
    end else if (ctl_jump || ctl_draw || frame_done) begin
      chk("pulse_spacing", int'(prev_pulse), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'({ctl_jump, ctl_draw, frame_done}), 0);
      end else begin
        got_e = exp_q.pop_front();
        exp_p = (got_e.kind == 2'd0) ? 3'b100 : (got_e.kind == 2'd3) ? 3'b001 : 3'b010;
        chk("ev_pulses", int'({ctl_jump, ctl_draw, frame_done}), int'(exp_p));
        chk("ev_travel", int'(ctl_travel), int'(got_e.travel));
        chk("ev_x", int'(ctl_x), int'(got_e.x));
        chk("ev_y", int'(ctl_y), int'(got_e.y));
        chk("ev_parked", int'(parked), int'(got_e.parked));
        cur_x = got_e.x;
        cur_y = got_e.y;
        if (!got_e.is_park) n_popped++;
      end
      prev_pulse = 1'b1;
    end else begin
      chk("hold_xy", int'({ctl_x, ctl_y}), int'({cur_x, cur_y}));
      prev_pulse = 1'b0;
    end
  end

  int          last_cyc;
  int          npulse;
  int          wait_n;
  logic [1:0]  r_op;

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_x     = 12'd0;
    cmd_y     = 12'd0;
    ctl_ready = 1'b0;
    do_reset();
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_level", int'(fifo_level), 0);

    // Single DRAW into an empty FIFO: pulse in the cycle after the pop edge.
    step(1'b1, 2'd1, 12'd100, 12'd200, 1'b1);
    chk("lat_no_early_pulse", int'(ctl_draw), 0);
    step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
    chk("lat_draw_pulse", int'(ctl_draw), 1);
    step(1'b0, 2'd0, 12'd0, 12'd0, 1'b0);
    chk("lat_draw_one_cycle", int'(ctl_draw), 0);
    drain("lat");

    // Fill to DEPTH with control stalled; a 17th push must be refused.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 1'b0);
    end
    chk("full_level", int'(fifo_level), 16);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    step(1'b1, 2'd1, 12'd1, 12'd1, 1'b0);
    chk("full_refused", int'(fifo_level), 16);
    last_cyc = 0;
    npulse   = 0;
    for (int c = 1; c <= 40 && npulse < 16; c++) begin
      step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
      if (ctl_jump || ctl_draw || frame_done) begin
        if (npulse > 0) chk("issue_rate", c - last_cyc, 2);
        last_cyc = c;
        npulse++;
      end
    end
    chk("full_issue_count", npulse, 16);
    drain("full");

    // JUMP(0,0), TRAVEL(4095,4095), END_FRAME keeps the travel coordinates.
    step(1'b1, 2'd0, 12'd0, 12'd0, 1'b0);
    step(1'b1, 2'd2, 12'd4095, 12'd4095, 1'b0);
    step(1'b1, 2'd3, 12'd5, 12'd6, 1'b0);
    drain("jte");

    // Starvation: park jump after 8 starved idle cycles, then hold parked.
    do_reset();
    expect_park();
    wait_n = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
      if (ctl_jump) begin
        wait_n = n;
        break;
      end
    end
    chk("park_delay", wait_n, 9);
    repeat (12) step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
    chk("parked_level", int'(parked), 1);
    step(1'b1, 2'd1, 12'd7, 12'd9, 1'b1);
    drain("unpark");
    chk("unparked", int'(parked), 0);

    // Randomized traffic with control ready only while work is outstanding.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) < 3, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), ($urandom_range(0, 3) != 0) && (n_pushed != n_popped));
    end
    drain("random");

    // Reset in HOLD with five entries still queued.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'($urandom_range(0, 2)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 1'b0);
    end
    npulse = 0;
    for (int i = 0; i < 6 && npulse == 0; i++) begin
      step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
      if (ctl_jump || ctl_draw || frame_done) npulse = 1;
    end
    chk("mid_hold_pulse", npulse, 1);
    chk("mid_hold_level", int'(fifo_level), 5);
    reset_begin();
    @(posedge clk);
    #1;
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_pulses", int'({ctl_jump, ctl_draw, frame_done}), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) step(1'b0, 2'd0, 12'd0, 12'd0, 1'b1);
    chk("mid_no_stale", int'(fifo_level), 0);

    // Three frames of four vectors each.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < 4; v++) begin
        r_op = 2'($urandom_range(0, 2));
        step(1'b1, r_op, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0);
      end
      step(1'b1, 2'd3, 12'd0, 12'd0, 1'b0);
    end
    chk("frames_level", int'(fifo_level), 15);
    drain("frames");
`ifdef VECTOR_SEQ_STATS_EN
    chk("stats_frame_count", int'(frame_count), 3);
    chk("stats_vector_last", int'(vector_count_last), 4);
    chk("stats_vector_count", int'(vector_count), 0);
`endif
    step(1'b0, 2'd0, 12'd0, 12'd0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Sits between the host/display-list source and the beam control block.
- Buffers a stream of vector commands (jump, draw, travel, end-of-frame) and issues each command as a single-cycle pulse when control reports ready.
- Holds the command coordinates stable while control uses them.
- Parks the beam at a safe position when starved, so a stopped host never leaves a bright dot on the tube.

Parameters:
- DEPTH, 16, command FIFO entries; must be a power of 2, at least 2.
- PARK_TIMEOUT, 4096, consecutive starved cycles before an automatic park jump.
- PARK_X, 2048, park X coordinate (12-bit).
- PARK_Y, 2048, park Y coordinate (12-bit).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  2  0=JUMP, 1=DRAW, 2=TRAVEL, 3=END_FRAME.
- cmd_x  in  12  target X.
- cmd_y  in  12  target Y.
- ctl_ready  in  1  control idle and able to accept a command.
- ctl_x  out  12  coordinate to control.
- ctl_y  out  12  coordinate to control.
- ctl_jump  out  1  one-cycle jump pulse.
- ctl_draw  out  1  one-cycle draw pulse.
- ctl_travel  out  1  level, qualifies ctl_draw.
- frame_done  out  1  one-cycle pulse when END_FRAME retires.
- parked  out  1  beam sits at the park point.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1, ctl_x=PARK_X, ctl_y=PARK_Y. Reset flushes the FIFO, clears the starve counter and returns to IDLE. Reset mid-command abandons it with no pulse.
- Push: occurs when cmd_valid && cmd_ready. Push and pop in the same cycle are legal; level stays unchanged. No push while full. Pop only when non-empty.
- IDLE:
  - If non-empty and ctl_ready: pop the head, register outputs, go to HOLD.
  - JUMP: ctl_jump=1.
  - DRAW: ctl_draw=1, ctl_travel=0.
  - TRAVEL: ctl_draw=1, ctl_travel=1.
  - For JUMP, DRAW and TRAVEL, ctl_x/ctl_y load the command coordinates.
  - END_FRAME: frame_done=1. No control pulse. ctl_x/ctl_y unchanged.
- HOLD: lasts exactly one cycle. All pulses drop to 0 and ctl_ready is ignored, which covers control's one-cycle ready lag. Then return to IDLE.
- Latency: a command written at edge E into an empty FIFO, with ctl_ready high, produces its pulse during the cycle after edge E+1. Back-to-back issue rate is at most one command per 2 cycles.
- Coordinate hold: ctl_x/ctl_y change only when a JUMP/DRAW/TRAVEL issues or a park occurs. Control samples them late during a jump.
- ctl_travel: a level that holds its last value; updated only on DRAW/TRAVEL issue.
- Starve counter: 13-bit, saturating.
  - Increments each IDLE cycle where the FIFO is empty, ctl_ready=1 and parked=0.
  - Clears on any pop.
  - When it reaches PARK_TIMEOUT: issue ctl_jump with PARK_X/PARK_Y, set parked=1, go to HOLD.
- parked clears on the next JUMP/DRAW/TRAVEL issue. END_FRAME does not clear it.
- PARK_TIMEOUT=0 disables auto-park.
- Simultaneous events: if FIFO non-empty and timeout are reached in the same cycle, the FIFO command wins and the counter clears.

Optional Feature:
- Macro: VECTOR_SEQ_STATS_EN.
- Defined: adds outputs frame_count[15:0] and vector_count[15:0].
  - vector_count increments on every JUMP/DRAW/TRAVEL issue; park jumps are excluded.
  - vector_count latches into a visible vector_count_last and clears on END_FRAME.
  - frame_count increments on END_FRAME and wraps at 65535.
  - Both reset to 0.
- Undefined: the ports and counters are absent; everything else is identical.

Decomposition:
- Shared package vector_pkg:
  - op-code localparams OP_JUMP/OP_DRAW/OP_TRAVEL/OP_END_FRAME;
  - COORD_W=12;
  - a packed command struct {op, x, y}.
- One sub-module, vector_cmd_fifo: synchronous circular FIFO, 26-bit entries, count-based full/empty, pointers wrap modulo DEPTH. The sequencer FSM and park logic stay in vector_sequencer.

Test Plan:
- Push DRAW(100,200) into empty FIFO, ctl_ready=1: ctl_draw=1 for one cycle, ctl_travel=0, ctl_x=100, ctl_y=200, pulse one cycle after the HOLD-free issue edge as specified; x/y held until the next issue.
- Push 16 commands with ctl_ready=0: fifo_level=16, cmd_ready=0. A 17th push is refused. Raise ctl_ready: commands issue in order, one per 2 cycles.
- JUMP(0,0), TRAVEL(4095,4095), END_FRAME: jump pulse, then draw+travel=1, then frame_done pulse with ctl_x/ctl_y still 4095.
- Starve with PARK_TIMEOUT=8, ctl_ready=1: after 8 idle cycles ctl_jump issues to (2048,2048) and parked=1. A subsequent DRAW clears parked.
- Assert reset while 5 entries are queued and HOLD is active: next cycle fifo_level=0, all pulses 0, cmd_ready=1. No stale command issues afterwards.
- With VECTOR_SEQ_STATS_EN, run 3 frames of 4 vectors each: frame_count=3, vector_count_last=4.
